ahb_usb_slave_pw: RTL and testbench
===================================

Name: ahb_usb_slave_pw

Overview:
Next-generation AHB-Lite subordinate bridging a host bus to the USB endpoint data buffer, RX packet decoder and TX packet encoder. Data bus width is parametrised. A byte-serialising FSM moves each beat into or out of the data buffer one byte per cycle, stalling the bus with hready. The block adds a proper two-cycle AHB ERROR response, buffer under/overflow checking, and self-clearing control registers.

Parameters:
DATA_W, 32, bus width in bits; legal values 32 or 64; NB = DATA_W/8 byte lanes.
BUF_DEPTH, 64, data buffer capacity in bytes; OCC_W = $clog2(BUF_DEPTH+1).

Ports:
clk  in  1  system clock
n_rst  in  1  reset; one clock; reset is asynchronous and active-low
hsel  in  1  AHB select
haddr  in  5  byte address
htrans  in  2  transfer type; only NONSEQ (2'b10) and SEQ (2'b11) start a transfer
hsize  in  3  size; 0=byte, 1=half, 2=word, 3=dword (DATA_W=64 only)
hwrite  in  1  write strobe
hwdata  in  DATA_W  write data
hrdata  out  DATA_W  read data
hready  out  1  transfer done / stall
hresp  out  1  ERROR response
rx_packet  in  4  decoded PID
rx_data_ready  in  1  RX packet complete
rx_transfer_active  in  1  RX in progress
rx_error  in  1  RX error
tx_transfer_active  in  1  TX in progress
tx_error  in  1  TX error
buffer_occupancy  in  OCC_W  bytes held in buffer
rx_data  in  8  buffer head byte (show-ahead, valid same cycle)
get_rx_data  out  1  pop one byte
store_tx_data  out  1  push tx_data
tx_data  out  8  byte to push
clear  out  1  buffer flush pulse
tx_packet  out  4  PID to send
d_mode  out  1  1 while TX active

Behaviour:
- Reset: hrdata=0, hready=1, hresp=0, get_rx_data=0, store_tx_data=0, tx_data=0, clear=0, tx_packet=0, d_mode=0. All registers are 0 and the FSM is in IDLE.
- Map: 0x00..NB-1 data window; 0x08 status (RO); 0x0A error (RO); 0x0C occupancy (RO); 0x10 tx_ctrl (RW); 0x11 flush (RW).
- Status bits: [0] rx_data_ready, [1] IN(1001), [2] OUT(0001), [3] ACK(0010), [4] NAK(1010), [8] rx_transfer_active, [9] tx_transfer_active.
- Error bits: [0] rx_error, [8] tx_error.
- Address phase is registered. Lanes = 2^hsize bytes starting at haddr[log2(NB)-1:0].
- Error conditions, each giving a two-cycle ERROR response:
  - unaligned access;
  - hsize > log2(NB);
  - unmapped address;
  - write to an RO register;
  - data-window read with occupancy < lanes;
  - data-window write with occupancy + lanes > BUF_DEPTH.
- Two-cycle ERROR: cycle 1 hresp=1, hready=0; cycle 2 hresp=1, hready=1. No side effects occur.
- FSM states: IDLE, WR_SER, RD_SER, RD_DONE, ERR1, ERR2.
- Data-window write: IDLE -> WR_SER. One byte per cycle, ascending lane order: store_tx_data=1, tx_data = the selected hwdata byte. hready=0 until the last byte cycle, where hready=1, then back to IDLE. Latency = lanes cycles.
- Data-window read: IDLE -> RD_SER. get_rx_data=1 for lanes cycles, each rx_data captured into its lane (other lanes 0). Then RD_DONE: hrdata valid, hready=1. Latency = lanes+1 cycles.
- Register access completes with zero wait states. Read data is valid in the data phase.
- tx_ctrl write values: 1=DATA0(0011), 2=ACK(0010), 3=NAK(1010), 4=STALL(1110), 5=DATA1(1011); any other value is ignored.
  - tx_packet drives the PID for exactly one cycle after the write, otherwise 0.
  - tx_ctrl reads back its value until the falling edge of tx_transfer_active, which clears it.
- flush: writing 1 sets the register and pulses clear for one cycle. The register reads 1 until buffer_occupancy==0, then auto-clears. Other values are ignored.
- Simultaneous hardware clear and bus write in the same cycle: the bus write wins.
- IDLE/BUSY htrans, or hsel=0, produces an OKAY response with zero wait states.
- d_mode = tx_transfer_active registered (1-cycle delay).
- Reset mid-transfer aborts the FSM immediately. No further strobes are issued.

Optional Feature:
IRQ_EN defined:
- Adds output irq (1) and RW register 0x14 irq_enable, with the same bit layout as status.
- Adds a sticky pending register: it sets on the rising edge of each status bit and of rx_error/tx_error (mapped to bits 16/24). It is write-1-to-clear at 0x15.
- irq = |(pending & enable), registered.
IRQ_EN undefined: no irq port; 0x14 and 0x15 are unmapped and return ERROR.

Test Plan:
- DATA_W=32, occupancy=0. Word write 0xA1B2C3D4 to 0x00 -> store_tx_data high for 4 cycles, tx_data D4,C3,B2,A1, hready low for 3 cycles, then OKAY.
- Occupancy=4, rx_data FIFO 11,22,33,44. Word read at 0x00 -> get_rx_data for 4 cycles, hrdata=0x44332211 on completion. A byte read at 0x02 with FIFO head 0x55 -> hrdata=0x00550000.
- Occupancy=1, half read at 0x00 -> ERROR (hresp=1/hready=0, then hresp=1/hready=1), get_rx_data never asserted. Write to 0x08 -> ERROR.
- Write 3 to 0x10 -> tx_packet=1010 for one cycle. Raise then drop tx_transfer_active -> 0x10 reads 0. Write 1 to 0x11 -> clear pulses once; register reads 1 until occupancy=0.
- DATA_W=64: dword write 0x0102030405060708 -> 8 bytes pushed 08..01. With DATA_W=32, hsize=3 -> ERROR.
- IRQ_EN: enable bit0, pulse rx_data_ready -> irq=1. Write 1 to 0x15 -> irq=0 the next cycle.

Source files
------------

// File: rtl/ahb_usb_slave_pw.sv
// AHB-Lite subordinate bridging a host bus to a USB endpoint buffer and RX/TX packet engines.
// Optional interrupt logic (irq output, 0x14 irq_enable, 0x15 W1C pending) is built when IRQ_EN is defined.
module ahb_usb_slave_pw #(
  parameter int DATA_W    = 32,
  parameter int BUF_DEPTH = 64,
  localparam int NB       = DATA_W / 8,
  localparam int LW       = $clog2(NB),
  localparam int OCC_W    = $clog2(BUF_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              hsel,
  input  logic [4:0]        haddr,
  input  logic [1:0]        htrans,
  input  logic [2:0]        hsize,
  input  logic              hwrite,
  input  logic [DATA_W-1:0] hwdata,
  output logic [DATA_W-1:0] hrdata,
  output logic              hready,
  output logic              hresp,
  input  logic [3:0]        rx_packet,
  input  logic              rx_data_ready,
  input  logic              rx_transfer_active,
  input  logic              rx_error,
  input  logic              tx_transfer_active,
  input  logic              tx_error,
  input  logic [OCC_W-1:0]  buffer_occupancy,
  input  logic [7:0]        rx_data,
  output logic              get_rx_data,
  output logic              store_tx_data,
  output logic [7:0]        tx_data,
  output logic              clear,
  output logic [3:0]        tx_packet,
`ifdef IRQ_EN
  output logic              irq,
`endif
  output logic              d_mode
);

  typedef enum logic [2:0] {IDLE, WR_SER, RD_SER, RD_DONE, ERR1, ERR2} state_e;

  localparam logic [4:0] A_STATUS  = 5'h08;
  localparam logic [4:0] A_ERROR   = 5'h0A;
  localparam logic [4:0] A_OCC     = 5'h0C;
  localparam logic [4:0] A_TXCTRL  = 5'h10;
  localparam logic [4:0] A_FLUSH   = 5'h11;
  localparam logic [4:0] A_IRQEN   = 5'h14;
  localparam logic [4:0] A_IRQPEND = 5'h15;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_STALL = 4'b1110;

  state_e            state_q, state_d;
  logic [LW-1:0]     cnt_q, cnt_d, last_q, last_d, base_q, base_d, lane_idx;
  logic [4:0]        addr_q, addr_d;
  logic              reg_rd_q, reg_rd_d, reg_wr_q, reg_wr_d;
  logic [DATA_W-1:0] rbuf_q, rbuf_d;
  logic [2:0]        tx_ctrl_q, tx_ctrl_d;
  logic [3:0]        tx_pid_q, tx_pid_d;
  logic              flush_q, flush_d, clear_q, clear_d, d_mode_q;

  // Address-phase decode
  logic              xfer_req, size_bad, misalign, is_win, is_ro, is_rw, dec_err;
  logic [3:0]        lanes;
  logic [LW-1:0]     size_mask;
  logic [OCC_W:0]    occ_ext, lanes_ext;
  logic [31:0]       stat_w, rd_word;
  logic [DATA_W-1:0] rd_bus;
  logic [7:0]        wbyte;
  logic [3:0]        wr_pid;
  logic              pid_ok, tx_fall;

  // Bits [15:0] are the status register, [31:16] the error register.
  assign stat_w = {7'b0, tx_error, 7'b0, rx_error, 6'b0, tx_transfer_active, rx_transfer_active,
                   3'b0, rx_packet == PID_NAK, rx_packet == PID_ACK, rx_packet == PID_OUT,
                   rx_packet == PID_IN, rx_data_ready};

  assign xfer_req = hsel && (htrans == 2'b10 || htrans == 2'b11);
  assign lane_idx = base_q + cnt_q;
  assign tx_fall  = d_mode_q && !tx_transfer_active;
  assign wbyte    = 8'(hwdata >> {addr_q[LW-1:0], 3'b000});

  always_comb begin
    lanes     = 4'd1 << hsize;
    size_mask = LW'(lanes - 4'd1);
    occ_ext   = {1'b0, buffer_occupancy};
    lanes_ext = (OCC_W + 1)'(lanes);
    size_bad  = hsize > 3'(LW);
    misalign  = (haddr[LW-1:0] & size_mask) != '0;
    is_win    = haddr < 5'(NB);
    is_ro     = (haddr == A_STATUS) || (haddr == A_ERROR) || (haddr == A_OCC);
    is_rw     = (haddr == A_TXCTRL) || (haddr == A_FLUSH);
`ifdef IRQ_EN
    is_rw     = is_rw || (haddr == A_IRQEN) || (haddr == A_IRQPEND);
`endif
    dec_err   = size_bad || misalign || !(is_win || is_ro || is_rw) || (is_ro && hwrite) ||
                (is_win && !hwrite && (occ_ext < lanes_ext)) ||
                (is_win && hwrite && (occ_ext + lanes_ext > (OCC_W + 1)'(BUF_DEPTH)));
  end

  // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latches).
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_d        = last_q;
    base_d        = base_q;
    addr_d        = addr_q;
    rbuf_d        = rbuf_q;
    reg_rd_d      = 1'b0;
    reg_wr_d      = 1'b0;
    hready        = 1'b1;
    hresp         = 1'b0;
    store_tx_data = 1'b0;
    get_rx_data   = 1'b0;
    tx_data       = '0;
    case (state_q)
      WR_SER: begin
        store_tx_data = 1'b1;
        tx_data       = hwdata[{lane_idx, 3'b000} +: 8];
        if (cnt_q == last_q) state_d = IDLE;
        else begin
          hready = 1'b0;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      RD_SER: begin
        get_rx_data = 1'b1;
        hready      = 1'b0;
        rbuf_d[{lane_idx, 3'b000} +: 8] = rx_data;
        if (cnt_q == last_q) state_d = RD_DONE;
        else cnt_d = cnt_q + 1'b1;
      end
      ERR1: begin
        hresp   = 1'b1;
        hready  = 1'b0;
        state_d = ERR2;
      end
      RD_DONE, ERR2: begin
        hresp   = (state_q == ERR2);
        state_d = IDLE;
      end
      default: ;
    endcase
    // A new address phase is accepted on any cycle that completes the previous one.
    if (hready && xfer_req) begin
      addr_d = haddr;
      base_d = haddr[LW-1:0];
      last_d = size_mask;
      cnt_d  = '0;
      if (dec_err) state_d = ERR1;
      else if (is_win) begin
        state_d = hwrite ? WR_SER : RD_SER;
        if (!hwrite) rbuf_d = '0;
      end else begin
        state_d  = IDLE;
        reg_rd_d = !hwrite;
        reg_wr_d = hwrite;
      end
    end
  end

`ifdef IRQ_EN
  localparam logic [31:0] IRQ_MASK = 32'h0101_03FF;
  logic [31:0] en_q, en_d, pend_q, pend_d, stat_q, w1c, wword;
  logic        irq_q, irq_d;
  assign wword = 32'(hwdata >> {addr_q[LW-1:0], 3'b000});
  assign irq   = irq_q;
`endif

  always_comb begin
    tx_ctrl_d = tx_fall ? '0 : tx_ctrl_q;
    flush_d   = (buffer_occupancy == '0) ? 1'b0 : flush_q;
    tx_pid_d  = '0;
    clear_d   = 1'b0;
    pid_ok    = 1'b1;
    case (wbyte)
      8'd1:    wr_pid = PID_DATA0;
      8'd2:    wr_pid = PID_ACK;
      8'd3:    wr_pid = PID_NAK;
      8'd4:    wr_pid = PID_STALL;
      8'd5:    wr_pid = PID_DATA1;
      default: begin
        wr_pid = '0;
        pid_ok = 1'b0;
      end
    endcase
    // Bus writes are applied after the hardware clears so they take priority.
    if (reg_wr_q && addr_q == A_TXCTRL && pid_ok) begin
      tx_ctrl_d = wbyte[2:0];
      tx_pid_d  = wr_pid;
    end
    if (reg_wr_q && addr_q == A_FLUSH && wbyte == 8'd1) begin
      flush_d = 1'b1;
      clear_d = 1'b1;
    end
`ifdef IRQ_EN
    en_d = en_q;
    w1c  = '0;
    if (reg_wr_q && addr_q == A_IRQEN)   en_d = wword & IRQ_MASK;
    if (reg_wr_q && addr_q == A_IRQPEND) w1c  = wword;
    pend_d = (pend_q | (stat_w & ~stat_q)) & ~w1c;
    irq_d  = |(pend_d & en_d);
`endif
  end

  always_comb begin
    rd_word = '0;
    case (addr_q)
      A_STATUS: rd_word[15:0]      = stat_w[15:0];
      A_ERROR:  rd_word[15:0]      = stat_w[31:16];
      A_OCC:    rd_word[OCC_W-1:0] = buffer_occupancy;
      A_TXCTRL: rd_word[2:0]       = tx_ctrl_q;
      A_FLUSH:  rd_word[0]         = flush_q;
`ifdef IRQ_EN
      A_IRQEN:   rd_word = en_q;
      A_IRQPEND: rd_word = pend_q;
`endif
      default: ;
    endcase
    rd_bus        = '0;
    rd_bus[31:0]  = rd_word;
    hrdata        = '0;
    if (state_q == RD_DONE) hrdata = rbuf_q;
    else if (reg_rd_q)      hrdata = rd_bus << {addr_q[LW-1:0], 3'b000};
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the read assembly buffer is reset too, so hrdata is a known 0 from reset onward.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= '0;
      base_q    <= '0;
      addr_q    <= '0;
      reg_rd_q  <= 1'b0;
      reg_wr_q  <= 1'b0;
      rbuf_q    <= '0;
      tx_ctrl_q <= '0;
      tx_pid_q  <= '0;
      flush_q   <= 1'b0;
      clear_q   <= 1'b0;
      d_mode_q  <= 1'b0;
`ifdef IRQ_EN
      en_q      <= '0;
      pend_q    <= '0;
      stat_q    <= '0;
      irq_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      base_q    <= base_d;
      addr_q    <= addr_d;
      reg_rd_q  <= reg_rd_d;
      reg_wr_q  <= reg_wr_d;
      rbuf_q    <= rbuf_d;
      tx_ctrl_q <= tx_ctrl_d;
      tx_pid_q  <= tx_pid_d;
      flush_q   <= flush_d;
      clear_q   <= clear_d;
      d_mode_q  <= tx_transfer_active;
`ifdef IRQ_EN
      en_q      <= en_d;
      pend_q    <= pend_d;
      stat_q    <= stat_w;
      irq_q     <= irq_d;
`endif
    end
  end

  assign clear     = clear_q;
  assign tx_packet = tx_pid_q;
  assign d_mode    = d_mode_q;

endmodule

// File: tb/tb_ahb_usb_slave_pw.sv
// Directed bench for ahb_usb_slave_pw: a 32-bit instance for most steps and a 64-bit one for dword transfers.
module tb_ahb_usb_slave_pw;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        hsel32, hsel64, hwrite;
  logic [4:0]  haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] hwdata32, hrdata32;
  logic [63:0] hwdata64, hrdata64;
  logic        hready32, hresp32, get32, store32, clear32, dmode32;
  logic        hready64, hresp64, get64, store64, clear64, dmode64;
  logic [7:0]  txd32, txd64, rx_data;
  logic [3:0]  txp32, txp64, rx_packet;
  logic        rx_data_ready, rx_transfer_active, rx_error, tx_transfer_active, tx_error;
  logic [6:0]  occ;
`ifdef IRQ_EN
  logic        irq32, irq64;
`endif

  logic [7:0]  fifo_mem [0:15];
  logic [3:0]  pops;

  int          n_checks = 0;
  int          n_fail   = 0;

  int          r_waits, r_stores, r_gets;
  logic        r_err1, r_resp, r_done;
  logic [63:0] r_bytes, r_rdata;

  always #5 clk = ~clk;

  ahb_usb_slave_pw #(.DATA_W(32), .BUF_DEPTH(64)) u32 (
    .clk(clk), .n_rst(n_rst), .hsel(hsel32), .haddr(haddr), .htrans(htrans), .hsize(hsize),
    .hwrite(hwrite), .hwdata(hwdata32), .hrdata(hrdata32), .hready(hready32), .hresp(hresp32),
    .rx_packet(rx_packet), .rx_data_ready(rx_data_ready), .rx_transfer_active(rx_transfer_active),
    .rx_error(rx_error), .tx_transfer_active(tx_transfer_active), .tx_error(tx_error),
    .buffer_occupancy(occ), .rx_data(rx_data), .get_rx_data(get32), .store_tx_data(store32),
    .tx_data(txd32), .clear(clear32), .tx_packet(txp32),
`ifdef IRQ_EN
    .irq(irq32),
`endif
    .d_mode(dmode32));

  ahb_usb_slave_pw #(.DATA_W(64), .BUF_DEPTH(64)) u64 (
    .clk(clk), .n_rst(n_rst), .hsel(hsel64), .haddr(haddr), .htrans(htrans), .hsize(hsize),
    .hwrite(hwrite), .hwdata(hwdata64), .hrdata(hrdata64), .hready(hready64), .hresp(hresp64),
    .rx_packet(rx_packet), .rx_data_ready(rx_data_ready), .rx_transfer_active(rx_transfer_active),
    .rx_error(rx_error), .tx_transfer_active(tx_transfer_active), .tx_error(tx_error),
    .buffer_occupancy(occ), .rx_data(rx_data), .get_rx_data(get64), .store_tx_data(store64),
    .tx_data(txd64), .clear(clear64), .tx_packet(txp64),
`ifdef IRQ_EN
    .irq(irq64),
`endif
    .d_mode(dmode64));

  // Show-ahead RX FIFO model: head byte advances after each pop by the 32-bit instance.
  assign rx_data = fifo_mem[pops];
  always @(posedge clk or negedge n_rst)
    if (!n_rst) pops <= '0;
    else if (get32) pops <= pops + 4'd1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One AHB transfer; records wait states, error phases, strobes and final read data.
  task automatic xfer(input string tag, input bit w64, input logic [4:0] addr,
                      input logic [2:0] size, input logic wr, input logic [63:0] wdata);
    logic rdy, rsp;
    r_waits = 0; r_stores = 0; r_gets = 0; r_err1 = 0; r_resp = 0; r_done = 0;
    r_bytes = '0; r_rdata = '0;
    @(negedge clk);
    haddr = addr; hsize = size; hwrite = wr; htrans = 2'b10;
    if (w64) hsel64 = 1'b1; else hsel32 = 1'b1;
    @(negedge clk);
    hsel32 = 1'b0; hsel64 = 1'b0; htrans = 2'b00;
    hwdata32 = wdata[31:0]; hwdata64 = wdata;
    for (int c = 0; c < 20; c++) begin
      #1;
      rdy = w64 ? hready64 : hready32;
      rsp = w64 ? hresp64 : hresp32;
      if (w64 ? store64 : store32) begin
        r_stores++;
        r_bytes = {r_bytes[55:0], (w64 ? txd64 : txd32)};
      end
      if (w64 ? get64 : get32) r_gets++;
      if (!rdy) begin
        r_waits++;
        if (rsp) r_err1 = 1'b1;
      end else begin
        r_resp  = rsp;
        r_rdata = w64 ? hrdata64 : {32'b0, hrdata32};
        r_done  = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_completed"}, r_done, 1'b1);
  endtask

  task automatic expect_error(input string tag);
    check({tag, "_err_cycle1"}, r_err1, 1'b1);
    check({tag, "_err_cycle2"}, r_resp, 1'b1);
    check({tag, "_err_waits"}, r_waits, 1);
    check({tag, "_no_strobes"}, r_stores + r_gets, 0);
  endtask

  initial begin
    n_rst = 1'b0; hsel32 = 0; hsel64 = 0; haddr = '0; htrans = '0; hsize = '0; hwrite = 0;
    hwdata32 = '0; hwdata64 = '0; rx_packet = '0; rx_data_ready = 0; rx_transfer_active = 0;
    rx_error = 0; tx_transfer_active = 0; tx_error = 0; occ = '0;
    for (int i = 0; i < 16; i++) fifo_mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check("rst_hready", hready32, 1'b1);
    check("rst_hresp", hresp32, 1'b0);
    check("rst_hrdata", hrdata32, 32'h0);
    check("rst_strobes", {get32, store32, clear32, dmode32}, 4'b0000);
    check("rst_tx_packet_data", {txp32, txd32}, 12'h000);
    @(negedge clk); n_rst = 1'b1;

    // Word write into the data window
    occ = 7'd0;
    xfer("wr_word", 1'b0, 5'h00, 3'd2, 1'b1, 64'hA1B2C3D4);
    check("wr_word_stores", r_stores, 4);
    check("wr_word_bytes", r_bytes, 64'hD4C3B2A1);
    check("wr_word_waits", r_waits, 3);
    check("wr_word_resp", r_resp, 1'b0);

    // Boundary: exactly filling the buffer is legal, one more lane overflows
    occ = 7'd60;
    xfer("wr_fill", 1'b0, 5'h00, 3'd2, 1'b1, 64'h01020304);
    check("wr_fill_stores", r_stores, 4);
    check("wr_fill_resp", r_resp, 1'b0);
    occ = 7'd62;
    xfer("wr_ovf", 1'b0, 5'h00, 3'd2, 1'b1, 64'h01020304);
    expect_error("wr_ovf");

    // Word read, then a byte read from lane 2
    occ = 7'd4;
    fifo_mem[pops]        = 8'h11;
    fifo_mem[pops + 4'd1] = 8'h22;
    fifo_mem[pops + 4'd2] = 8'h33;
    fifo_mem[pops + 4'd3] = 8'h44;
    xfer("rd_word", 1'b0, 5'h00, 3'd2, 1'b0, 64'h0);
    check("rd_word_gets", r_gets, 4);
    check("rd_word_waits", r_waits, 4);
    check("rd_word_data", r_rdata, 64'h44332211);
    fifo_mem[pops] = 8'h55;
    xfer("rd_byte2", 1'b0, 5'h02, 3'd0, 1'b0, 64'h0);
    check("rd_byte2_gets", r_gets, 1);
    check("rd_byte2_data", r_rdata, 64'h00550000);

    // Error responses
    occ = 7'd1;
    xfer("rd_under", 1'b0, 5'h00, 3'd1, 1'b0, 64'h0);
    expect_error("rd_under");
    occ = 7'd4;
    xfer("rd_unalign", 1'b0, 5'h02, 3'd2, 1'b0, 64'h0);
    expect_error("rd_unalign");
    xfer("wr_ro", 1'b0, 5'h08, 3'd0, 1'b1, 64'h1);
    expect_error("wr_ro");
    xfer("unmapped", 1'b0, 5'h1C, 3'd0, 1'b1, 64'h1);
    expect_error("unmapped");
    xfer("size_dword32", 1'b0, 5'h00, 3'd3, 1'b1, 64'h1);
    expect_error("size_dword32");
`ifndef IRQ_EN
    xfer("irqen_absent", 1'b0, 5'h14, 3'd0, 1'b1, 64'h1);
    expect_error("irqen_absent");
`endif

    // Read-only registers
    rx_data_ready = 1'b1; rx_packet = 4'b1001;
    xfer("rd_status", 1'b0, 5'h08, 3'd1, 1'b0, 64'h0);
    check("rd_status_data", r_rdata, 64'h0003);
    check("rd_status_waits", r_waits, 0);
    rx_data_ready = 1'b0; rx_packet = 4'b0000; rx_error = 1'b1;
    xfer("rd_error", 1'b0, 5'h0A, 3'd1, 1'b0, 64'h0);
    check("rd_error_data", r_rdata, 64'h0001_0000);
    rx_error = 1'b0; occ = 7'd37;
    xfer("rd_occ", 1'b0, 5'h0C, 3'd0, 1'b0, 64'h0);
    check("rd_occ_data", r_rdata, 64'h25);

    // tx_ctrl: one-cycle PID pulse, read-back, clear on falling tx_transfer_active
    xfer("wr_txctrl", 1'b0, 5'h10, 3'd0, 1'b1, 64'h3);
    check("wr_txctrl_waits", r_waits, 0);
    check("txpkt_in_data_phase", txp32, 4'b0000);
    @(negedge clk); #1;
    check("txpkt_pulse", txp32, 4'b1010);
    @(negedge clk); #1;
    check("txpkt_after", txp32, 4'b0000);
    xfer("wr_txctrl_bad", 1'b0, 5'h10, 3'd0, 1'b1, 64'h7);
    @(negedge clk); #1;
    check("txpkt_bad_value", txp32, 4'b0000);
    xfer("rd_txctrl", 1'b0, 5'h10, 3'd0, 1'b0, 64'h0);
    check("rd_txctrl_data", r_rdata, 64'h3);
    tx_transfer_active = 1'b1;
    @(negedge clk); #1;
    check("d_mode_high", dmode32, 1'b1);
    tx_transfer_active = 1'b0;
    @(negedge clk); #1;
    check("d_mode_low", dmode32, 1'b0);
    xfer("rd_txctrl_clr", 1'b0, 5'h10, 3'd0, 1'b0, 64'h0);
    check("rd_txctrl_clr_data", r_rdata, 64'h0);

    // flush: one clear pulse, holds while occupancy is non-zero
    occ = 7'd4;
    xfer("wr_flush", 1'b0, 5'h11, 3'd0, 1'b1, 64'h100);
    check("clear_in_data_phase", clear32, 1'b0);
    @(negedge clk); #1;
    check("clear_pulse", clear32, 1'b1);
    @(negedge clk); #1;
    check("clear_after", clear32, 1'b0);
    xfer("rd_flush", 1'b0, 5'h11, 3'd0, 1'b0, 64'h0);
    check("rd_flush_set", r_rdata, 64'h100);
    occ = 7'd0;
    xfer("rd_flush_clr", 1'b0, 5'h11, 3'd0, 1'b0, 64'h0);
    check("rd_flush_clr_data", r_rdata, 64'h0);

    // 64-bit instance: dword write
    xfer("wr_dword64", 1'b1, 5'h00, 3'd3, 1'b1, 64'h0102030405060708);
    check("wr_dword64_stores", r_stores, 8);
    check("wr_dword64_bytes", r_bytes, 64'h0807060504030201);
    check("wr_dword64_waits", r_waits, 7);
    check("wr_dword64_resp", r_resp, 1'b0);

`ifdef IRQ_EN
    xfer("wr_irqen", 1'b0, 5'h14, 3'd2, 1'b1, 64'h1);
    @(negedge clk); rx_data_ready = 1'b1;
    @(negedge clk); rx_data_ready = 1'b0;
    #1;
    check("irq_set", irq32, 1'b1);
    xfer("wr_irqclr", 1'b0, 5'h15, 3'd0, 1'b1, 64'h100);
    @(negedge clk); #1;
    check("irq_cleared", irq32, 1'b0);
`endif

    // Reset during a write aborts serialisation immediately
    occ = 7'd0;
    @(negedge clk);
    haddr = 5'h00; hsize = 3'd2; hwrite = 1'b1; htrans = 2'b10; hsel32 = 1'b1;
    @(negedge clk);
    hsel32 = 1'b0; htrans = 2'b00; hwdata32 = 32'hCAFEF00D;
    #1;
    check("abort_byte0", {store32, txd32}, {1'b1, 8'h0D});
    @(negedge clk); #1;
    check("abort_byte1", {store32, txd32}, {1'b1, 8'hF0});
    n_rst = 1'b0;
    #1;
    check("abort_store", store32, 1'b0);
    check("abort_hready", hready32, 1'b1);
    @(negedge clk); n_rst = 1'b1;
    @(negedge clk); #1;
    check("abort_idle", {store32, hready32}, 2'b01);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
